// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over a programmable window,
// then scans the counters sequentially to find the most active channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; window_len is captured on acceptance
// CLEAR   | one-cycle network reset pulse, counters forced to zero
// COUNT   | accumulate spike_in into saturating counters for N cycles
// ARGMAX  | visit one channel per cycle, tracking max / index / tie
// DONE    | one-cycle done pulse; winner outputs already hold the result
module spike_rate_decoder #(
    parameter int NUM_INPUTS   = 4,
    parameter int COUNTER_SIZE = 8,
    parameter int WINDOW_WIDTH = 16,
    localparam int WINNER_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [WINDOW_WIDTH-1:0]            window_len,
    input  logic [NUM_INPUTS-1:0]              spike_in,
    output logic                               net_rst,
    output logic                               busy,
    output logic                               done,
    output logic [WINNER_W-1:0]                winner,
    output logic [COUNTER_SIZE-1:0]            winner_count,
    output logic                               tie,
    output logic [NUM_INPUTS*COUNTER_SIZE-1:0] counts_flat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_ARGMAX,
        S_DONE
    } state_t;

    localparam logic [WINNER_W-1:0]     LAST_IDX = WINNER_W'(NUM_INPUTS - 1);
    localparam logic [COUNTER_SIZE-1:0] CNT_MAX  = '1;

    state_t                    state;
    state_t                    state_nxt;
    logic [WINDOW_WIDTH-1:0]   win_cnt;
    logic [COUNTER_SIZE-1:0]   cnt [NUM_INPUTS];

    logic [WINNER_W-1:0]       scan_idx;
    logic [WINNER_W-1:0]       scan_win;
    logic [COUNTER_SIZE-1:0]   scan_max;
    logic                      scan_tie;

    logic [WINNER_W-1:0]       sel_win;
    logic [COUNTER_SIZE-1:0]   sel_max;
    logic                      sel_tie;
    logic [COUNTER_SIZE-1:0]   cur_cnt;

    logic [WINNER_W-1:0]       win_r;
    logic [COUNTER_SIZE-1:0]   wc_r;
    logic                      tie_r;

    logic                      accept;

    assign accept = (state == S_IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero-length window skips COUNT entirely
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = (win_cnt == '0) ? S_ARGMAX : S_COUNT;
            S_COUNT:  if (win_cnt == WINDOW_WIDTH'(1)) state_nxt = S_ARGMAX;
            S_ARGMAX: if (scan_idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Window down-counter: loaded on acceptance, last COUNT cycle when it reads 1
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (accept) begin
            win_cnt <= window_len;
        end else if (state == S_COUNT) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end

    // Per-channel saturating spike counters; zeroed on acceptance so CLEAR already reads 0
    always_ff @(posedge clk) begin
        if (rst || accept || state == S_CLEAR) begin
            for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
        end else if (state == S_COUNT) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (spike_in[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Scan step: index 0 seeds, strictly greater replaces, equal keeps lower index and flags tie
    always_comb begin
        cur_cnt = cnt[scan_idx];
        sel_win = scan_win;
        sel_max = scan_max;
        sel_tie = scan_tie;
        if (scan_idx == '0) begin
            sel_win = '0;
            sel_max = cur_cnt;
            sel_tie = 1'b0;
        end else if (cur_cnt > scan_max) begin
            sel_win = scan_idx;
            sel_max = cur_cnt;
            sel_tie = 1'b0;
        end else if (cur_cnt == scan_max) begin
            sel_tie = 1'b1;
        end
    end

    // Scan bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx <= '0;
            scan_win <= '0;
            scan_max <= '0;
            scan_tie <= 1'b0;
        end else if (state == S_CLEAR) begin
            scan_idx <= '0;
        end else if (state == S_ARGMAX) begin
            scan_idx <= scan_idx + 1'b1;
            scan_win <= sel_win;
            scan_max <= sel_max;
            scan_tie <= sel_tie;
        end
    end

    // Published result: captured on the final scan step so it is visible during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r <= '0;
            wc_r  <= '0;
            tie_r <= 1'b0;
        end else if (state == S_ARGMAX && scan_idx == LAST_IDX) begin
            win_r <= sel_win;
            wc_r  <= sel_max;
            tie_r <= sel_tie;
        end
    end

    // Live counter view
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_flat
        assign counts_flat[g*COUNTER_SIZE +: COUNTER_SIZE] = cnt[g];
    end

    assign net_rst      = (state == S_CLEAR);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign winner       = win_r;
    assign winner_count = wc_r;
    assign tie          = tie_r;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder (4 channels, 4-bit counters).
// Cycle offsets are counted from the accepting edge: offset 1 is CLEAR.
module tb_spike_rate_decoder;

    localparam int NI = 4;
    localparam int CS = 4;
    localparam int WW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [WW-1:0]   window_len;
    logic [NI-1:0]   spike_in;
    logic            net_rst;
    logic            busy;
    logic            done;
    logic [1:0]      winner;
    logic [CS-1:0]   winner_count;
    logic            tie;
    logic [NI*CS-1:0] counts_flat;

    int total = 0;
    int bad   = 0;

    spike_rate_decoder #(
        .NUM_INPUTS  (NI),
        .COUNTER_SIZE(CS),
        .WINDOW_WIDTH(WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .window_len  (window_len),
        .spike_in    (spike_in),
        .net_rst     (net_rst),
        .busy        (busy),
        .done        (done),
        .winner      (winner),
        .winner_count(winner_count),
        .tie         (tie),
        .counts_flat (counts_flat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until done is seen or the budget runs out; returns the offset reached
    task automatic wait_done(input int from_off, output int off);
        off = from_off;
        while (!done && off < 100) begin
            tick();
            off++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; window_len = '0; spike_in = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({busy, done, net_rst, tie} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags busy/done/net_rst/tie got %b want 0000", {busy, done, net_rst, tie});
        end
        total++;
        if ({winner, winner_count, counts_flat} !== '0) begin
            bad++; $display("FAIL reset_data winner=%0d count=%0d flat=%h want all 0", winner, winner_count, counts_flat);
        end
    endtask

    task automatic test_single_channel();
        int off;
        int nr_bad;
        spike_in = 4'b0100; window_len = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (net_rst !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_clear net_rst=%b busy=%b want 1 1", net_rst, busy);
        end
        nr_bad = 0;
        off = 1;
        while (!done && off < 100) begin
            tick();
            off++;
            if (net_rst !== 1'b0) nr_bad++;
        end
        total++;
        if (nr_bad != 0) begin
            bad++; $display("FAIL single_net_rst_extra got %0d cycles high want 0", nr_bad);
        end
        total++;
        if (off != 16) begin
            bad++; $display("FAIL single_latency got offset %0d want 16", off);
        end
        total++;
        if (winner !== 2'd2 || winner_count !== 4'd10 || tie !== 1'b0) begin
            bad++; $display("FAIL single_result winner=%0d count=%0d tie=%b want 2 10 0", winner, winner_count, tie);
        end
        total++;
        if (counts_flat !== 16'h0A00) begin
            bad++; $display("FAIL single_counts got %h want 0a00", counts_flat);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || winner !== 2'd2) begin
            bad++; $display("FAIL single_after done=%b busy=%b winner=%0d want 0 0 2", done, busy, winner);
        end
    endtask

    task automatic test_tie();
        int off;
        spike_in = 4'b0000; window_len = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        spike_in = 4'b1111;
        tick();
        spike_in = 4'b1010;
        tick();
        total++;
        if (winner !== 2'd2 || winner_count !== 4'd10) begin
            bad++; $display("FAIL tie_held_prev winner=%0d count=%0d want 2 10", winner, winner_count);
        end
        tick(); tick(); tick();
        tick();
        spike_in = 4'b0000;
        wait_done(7, off);
        total++;
        if (off != 14) begin
            bad++; $display("FAIL tie_latency got offset %0d want 14", off);
        end
        total++;
        if (winner !== 2'd1 || winner_count !== 4'd5 || tie !== 1'b1) begin
            bad++; $display("FAIL tie_result winner=%0d count=%0d tie=%b want 1 5 1", winner, winner_count, tie);
        end
        total++;
        if (counts_flat !== 16'h5050) begin
            bad++; $display("FAIL tie_counts got %h want 5050", counts_flat);
        end
        tick();
    endtask

    task automatic test_saturate();
        int off;
        spike_in = 4'b0001; window_len = 16'd40; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, off);
        total++;
        if (off != 46) begin
            bad++; $display("FAIL sat_latency got offset %0d want 46", off);
        end
        total++;
        if (counts_flat !== 16'h000F || winner !== 2'd0 || winner_count !== 4'd15 || tie !== 1'b0) begin
            bad++; $display("FAIL sat_result flat=%h winner=%0d count=%0d tie=%b want 000f 0 15 0", counts_flat, winner, winner_count, tie);
        end
        spike_in = 4'b0000;
        tick();
    endtask

    task automatic test_zero_window();
        int off;
        spike_in = 4'b1111; window_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, off);
        total++;
        if (off != 6) begin
            bad++; $display("FAIL zero_latency got offset %0d want 6", off);
        end
        total++;
        if (counts_flat !== 16'h0000 || winner !== 2'd0 || winner_count !== 4'd0 || tie !== 1'b1) begin
            bad++; $display("FAIL zero_result flat=%h winner=%0d count=%0d tie=%b want 0000 0 0 1", counts_flat, winner, winner_count, tie);
        end
        spike_in = 4'b0000;
        tick();
    endtask

    task automatic test_midrun_changes();
        int off;
        int ndone;
        int first;
        spike_in = 4'b1000; window_len = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        window_len = 16'd3;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; first = 0; off = 4;
        while (off < 25) begin
            if (done) begin
                ndone++;
                if (first == 0) first = off;
            end
            tick();
            off++;
        end
        total++;
        if (ndone != 1 || first != 16) begin
            bad++; $display("FAIL midrun_done pulses=%0d first=%0d want 1 16", ndone, first);
        end
        total++;
        if (winner !== 2'd3 || winner_count !== 4'd10 || counts_flat !== 16'hA000) begin
            bad++; $display("FAIL midrun_result winner=%0d count=%0d flat=%h want 3 10 a000", winner, winner_count, counts_flat);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL midrun_idle busy=%b want 0", busy);
        end
        spike_in = 4'b0000;
    endtask

    task automatic test_back_to_back();
        int off;
        spike_in = 4'b0100; window_len = 16'd2; start = 1'b1;
        tick();
        wait_done(1, off);
        total++;
        if (off != 8) begin
            bad++; $display("FAIL b2b_latency got offset %0d want 8", off);
        end
        tick();
        total++;
        if (busy !== 1'b0 || net_rst !== 1'b0) begin
            bad++; $display("FAIL b2b_idle_gap busy=%b net_rst=%b want 0 0", busy, net_rst);
        end
        tick();
        start = 1'b0;
        total++;
        if (net_rst !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_restart net_rst=%b busy=%b want 1 1", net_rst, busy);
        end
        wait_done(10, off);
        total++;
        if (off != 17 || winner !== 2'd2 || winner_count !== 4'd2) begin
            bad++; $display("FAIL b2b_second offset=%0d winner=%0d count=%0d want 17 2 2", off, winner, winner_count);
        end
        spike_in = 4'b0000;
        tick();
    endtask

    task automatic test_rst_midrun();
        int off;
        spike_in = 4'b0010; window_len = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i <= 8; i++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || winner !== 2'd0 || counts_flat !== 16'h0000 ||
            winner_count !== 4'd0 || tie !== 1'b0) begin
            bad++; $display("FAIL rst_mid busy=%b done=%b winner=%0d count=%0d tie=%b flat=%h want all 0",
                            busy, done, winner, winner_count, tie, counts_flat);
        end
        rst = 1'b0;
        tick();
        window_len = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, off);
        total++;
        if (off != 9 || winner !== 2'd1 || winner_count !== 4'd3 || tie !== 1'b0) begin
            bad++; $display("FAIL rst_recover offset=%0d winner=%0d count=%0d tie=%b want 9 1 3 0", off, winner, winner_count, tie);
        end
        spike_in = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_tie();
        test_saturate();
        test_zero_window();
        test_midrun_changes();
        test_back_to_back();
        test_rst_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
